// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS core pipeline: state enum,
// memory access size codes and the ID/EX control bundle.
package cpu_pkg;

  localparam int unsigned ALUCTR_W = 5;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic                regdst;
    logic                branch;
    logic                memtoreg;
    logic                alusrc1;
    logic                alusrc2;
    logic                regwrite;
    logic                jump;
    logic [1:0]          memwrite;
    logic [1:0]          memread;
    logic [ALUCTR_W-1:0] aluctr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the instruction in EX and the
// source registers of the instruction in ID; shared with forwarding.
module hazard_detect
  import cpu_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic [1:0]    i_ex_memread,
  input  logic          i_ex_regwrite,
  input  logic [RW-1:0] i_ex_wa,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  output logic          o_load_use
);

  logic w_is_load;
  logic w_src_hit;

  assign w_is_load  = (i_ex_memread != MEM_NONE) && i_ex_regwrite && (i_ex_wa != '0);
  assign w_src_hit  = (i_ex_wa == i_id_rs) || (i_ex_wa == i_id_rt);
  assign o_load_use = w_is_load && w_src_hit;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush and sticky halt.
// Optional stall counter enabled by IDEX_STALL_STATS_EN.
module id_ex_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_regdst_i,
  input  logic                id_branch_i,
  input  logic                id_memtoreg_i,
  input  logic                id_alusrc1_i,
  input  logic                id_alusrc2_i,
  input  logic                id_regwrite_i,
  input  logic                id_jump_i,
  input  logic [1:0]          id_memwrite_i,
  input  logic [1:0]          id_memread_i,
  input  logic [ALUCTR_W-1:0] id_aluctr_i,
  input  logic                id_keep_i,
  input  logic [RW-1:0]       id_rs_i,
  input  logic [RW-1:0]       id_rt_i,
  input  logic [RW-1:0]       id_rd_i,
  input  logic [RW-1:0]       id_shamt_i,
  input  logic [DW-1:0]       id_busa_i,
  input  logic [DW-1:0]       id_busb_i,
  input  logic [DW-1:0]       id_imm_i,
  input  logic [DW-1:0]       id_pc4_i,
  input  logic                flush_i,
  output logic                ex_regdst_o,
  output logic                ex_branch_o,
  output logic                ex_memtoreg_o,
  output logic                ex_alusrc1_o,
  output logic                ex_alusrc2_o,
  output logic                ex_regwrite_o,
  output logic                ex_jump_o,
  output logic [1:0]          ex_memwrite_o,
  output logic [1:0]          ex_memread_o,
  output logic [ALUCTR_W-1:0] ex_aluctr_o,
  output logic [RW-1:0]       ex_rs_o,
  output logic [RW-1:0]       ex_rt_o,
  output logic [RW-1:0]       ex_rd_o,
  output logic [RW-1:0]       ex_shamt_o,
  output logic [DW-1:0]       ex_busa_o,
  output logic [DW-1:0]       ex_busb_o,
  output logic [DW-1:0]       ex_imm_o,
  output logic [DW-1:0]       ex_pc4_o,
  output logic [RW-1:0]       ex_wa_o,
  output logic                ctrl_o,
  output logic                pc_hold_o,
  output logic                ifid_hold_o,
  output logic                halt_o,
  output logic [31:0]         stall_cnt_o
);

  state_e        r_state;
  state_e        w_state_nx;
  ctrl_t         r_ctrl;
  ctrl_t         w_id_ctrl;
  logic [RW-1:0] r_rs, r_rt, r_rd, r_shamt, r_wa;
  logic [DW-1:0] r_busa, r_busb, r_imm, r_pc4;
  logic          w_load_use;
  logic          w_take;
  logic          w_hold;

  assign w_id_ctrl = '{regdst:   id_regdst_i,   branch:   id_branch_i,
                       memtoreg: id_memtoreg_i, alusrc1:  id_alusrc1_i,
                       alusrc2:  id_alusrc2_i,  regwrite: id_regwrite_i,
                       jump:     id_jump_i,     memwrite: id_memwrite_i,
                       memread:  id_memread_i,  aluctr:   id_aluctr_i};

  hazard_detect #(.RW(RW)) u_hazard (
    .i_ex_memread  (r_ctrl.memread),
    .i_ex_regwrite (r_ctrl.regwrite),
    .i_ex_wa       (r_wa),
    .i_id_rs       (id_rs_i),
    .i_id_rt       (id_rt_i),
    .o_load_use    (w_load_use)
  );

  // Priority in RUN: flush, then load-use stall, then illegal opcode, then load.
  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_hold     = 1'b0;
    if (r_state == HALT) begin
      w_hold = 1'b1;
    end else if (flush_i) begin
      w_hold = 1'b0;
    end else if (w_load_use) begin
      w_hold = 1'b1;
    end else if (id_keep_i) begin
      w_state_nx = HALT;
    end else begin
      w_take = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !w_take) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_shamt <= '0;
      r_wa    <= '0;
      r_busa  <= '0;
      r_busb  <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
    end else begin
      r_ctrl  <= w_id_ctrl;
      r_rs    <= id_rs_i;
      r_rt    <= id_rt_i;
      r_rd    <= id_rd_i;
      r_shamt <= id_shamt_i;
      r_wa    <= id_regdst_i ? id_rd_i : id_rt_i;
      r_busa  <= id_busa_i;
      r_busb  <= id_busb_i;
      r_imm   <= id_imm_i;
      r_pc4   <= id_pc4_i;
    end
  end

`ifdef IDEX_STALL_STATS_EN
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  assign w_stall = (r_state == RUN) && !flush_i && w_load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  assign ex_regdst_o   = r_ctrl.regdst;
  assign ex_branch_o   = r_ctrl.branch;
  assign ex_memtoreg_o = r_ctrl.memtoreg;
  assign ex_alusrc1_o  = r_ctrl.alusrc1;
  assign ex_alusrc2_o  = r_ctrl.alusrc2;
  assign ex_regwrite_o = r_ctrl.regwrite;
  assign ex_jump_o     = r_ctrl.jump;
  assign ex_memwrite_o = r_ctrl.memwrite;
  assign ex_memread_o  = r_ctrl.memread;
  assign ex_aluctr_o   = r_ctrl.aluctr;
  assign ex_rs_o       = r_rs;
  assign ex_rt_o       = r_rt;
  assign ex_rd_o       = r_rd;
  assign ex_shamt_o    = r_shamt;
  assign ex_busa_o     = r_busa;
  assign ex_busb_o     = r_busb;
  assign ex_imm_o      = r_imm;
  assign ex_pc4_o      = r_pc4;
  assign ex_wa_o       = r_wa;
  assign ctrl_o        = w_hold;
  assign pc_hold_o     = w_hold;
  assign ifid_hold_o   = w_hold;
  assign halt_o        = (r_state == HALT);

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed vector table, hand sequences
// for halt/stats, and randomized traffic against a behavioural model.
module tb_id_ex_pipe;

  typedef struct packed {
    logic        regdst, branch, memtoreg, alusrc1, alusrc2, regwrite, jump;
    logic [1:0]  memwrite, memread;
    logic [4:0]  aluctr;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] busa, busb, imm, pc4;
  } id_t;

  typedef struct {
    id_t        in;
    bit         flush;
    bit         keep;
    bit         exp_hold;
    logic [4:0] exp_aluctr;
    logic [4:0] exp_wa;
    bit         exp_rw;
    bit         exp_halt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  id_t         drv = '0;
  logic        flush = 1'b0;
  logic        keep = 1'b0;

  logic        ex_regdst, ex_branch, ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_regwrite, ex_jump;
  logic [1:0]  ex_memwrite, ex_memread;
  logic [4:0]  ex_aluctr, ex_rs, ex_rt, ex_rd, ex_shamt, ex_wa;
  logic [31:0] ex_busa, ex_busb, ex_imm, ex_pc4;
  logic        ctrl, pc_hold, ifid_hold, halt;
  logic [31:0] stall_cnt;
  id_t         ex_act;

  int n_chk  = 0;
  int n_fail = 0;

  id_t         m_ex;
  logic [4:0]  m_wa;
  bit          m_halt;
  int unsigned m_stalls;

  always #5 clk = ~clk;

  id_ex_pipe #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_regdst_i(drv.regdst), .id_branch_i(drv.branch), .id_memtoreg_i(drv.memtoreg),
    .id_alusrc1_i(drv.alusrc1), .id_alusrc2_i(drv.alusrc2), .id_regwrite_i(drv.regwrite),
    .id_jump_i(drv.jump), .id_memwrite_i(drv.memwrite), .id_memread_i(drv.memread),
    .id_aluctr_i(drv.aluctr), .id_keep_i(keep),
    .id_rs_i(drv.rs), .id_rt_i(drv.rt), .id_rd_i(drv.rd), .id_shamt_i(drv.shamt),
    .id_busa_i(drv.busa), .id_busb_i(drv.busb), .id_imm_i(drv.imm), .id_pc4_i(drv.pc4),
    .flush_i(flush),
    .ex_regdst_o(ex_regdst), .ex_branch_o(ex_branch), .ex_memtoreg_o(ex_memtoreg),
    .ex_alusrc1_o(ex_alusrc1), .ex_alusrc2_o(ex_alusrc2), .ex_regwrite_o(ex_regwrite),
    .ex_jump_o(ex_jump), .ex_memwrite_o(ex_memwrite), .ex_memread_o(ex_memread),
    .ex_aluctr_o(ex_aluctr), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
    .ex_shamt_o(ex_shamt), .ex_busa_o(ex_busa), .ex_busb_o(ex_busb), .ex_imm_o(ex_imm),
    .ex_pc4_o(ex_pc4), .ex_wa_o(ex_wa),
    .ctrl_o(ctrl), .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold), .halt_o(halt),
    .stall_cnt_o(stall_cnt)
  );

  always_comb
    ex_act = {ex_regdst, ex_branch, ex_memtoreg, ex_alusrc1, ex_alusrc2, ex_regwrite, ex_jump,
              ex_memwrite, ex_memread, ex_aluctr, ex_rs, ex_rt, ex_rd, ex_shamt,
              ex_busa, ex_busb, ex_imm, ex_pc4};

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: EX contents follow the ID/EX priority rules directly.
  function automatic bit m_load_use(input id_t in);
    return (m_ex.memread != 2'b00) && m_ex.regwrite && (m_wa != 5'd0) &&
           ((m_wa == in.rs) || (m_wa == in.rt));
  endfunction

  function automatic bit m_hold(input id_t in, input bit fl);
    return m_halt || (!fl && m_load_use(in));
  endfunction

  task automatic m_step(input id_t in, input bit fl, input bit kp, input bit rst);
    bit lu, run, bubble;
    if (rst) begin
      m_ex = '0; m_wa = '0; m_halt = 1'b0; m_stalls = 0;
      return;
    end
    lu     = m_load_use(in);
    run    = !m_halt;
    bubble = m_halt || fl || lu || kp;
    if (run && !fl && lu) m_stalls++;
    if (run && !fl && !lu && kp) m_halt = 1'b1;
    if (bubble) begin
      m_ex = '0; m_wa = '0;
    end else begin
      m_ex = in; m_wa = in.regdst ? in.rd : in.rt;
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef IDEX_STALL_STATS_EN
    return m_stalls;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input id_t in, input bit fl, input bit kp, input bit rn);
    drv = in; flush = fl; keep = kp; rst_n = rn;
  endtask

  task automatic rcycle(input id_t in, input bit fl, input bit kp, input bit rst);
    bit eh;
    drive(in, fl, kp, !rst);
    #1;
    if (!rst) begin
      eh = m_hold(in, fl);
      chk("ctrl", ctrl, eh);
      chk("pc_hold", pc_hold, eh);
      chk("ifid_hold", ifid_hold, eh);
    end
    @(posedge clk);
    m_step(in, fl, kp, rst);
    #1;
    chk("ex_bundle", {ex_act, ex_wa}, {m_ex, m_wa});
    chk("halt", halt, m_halt);
    chk("stall_cnt", stall_cnt, exp_cnt());
  endtask

  task automatic vcycle(input int idx, input vec_t v);
    drive(v.in, v.flush, v.keep, 1'b1);
    #1;
    chk($sformatf("v%0d_ctrl", idx), ctrl, v.exp_hold);
    chk($sformatf("v%0d_pc_hold", idx), pc_hold, v.exp_hold);
    chk($sformatf("v%0d_ifid_hold", idx), ifid_hold, v.exp_hold);
    @(posedge clk);
    m_step(v.in, v.flush, v.keep, 1'b0);
    #1;
    chk($sformatf("v%0d_aluctr", idx), ex_aluctr, v.exp_aluctr);
    chk($sformatf("v%0d_wa", idx), ex_wa, v.exp_wa);
    chk($sformatf("v%0d_regwrite", idx), ex_regwrite, v.exp_rw);
    chk($sformatf("v%0d_halt", idx), halt, v.exp_halt);
  endtask

  function automatic id_t rand_id();
    id_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r.rs = 5'($urandom_range(0, 3));
    r.rt = 5'($urandom_range(0, 3));
    r.rd = 5'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic vec_t mkv(input id_t in, input bit fl, input bit kp, input bit eh,
                               input logic [4:0] ea, input logic [4:0] ew, input bit er,
                               input bit ehl);
    vec_t v;
    v.in = in; v.flush = fl; v.keep = kp; v.exp_hold = eh;
    v.exp_aluctr = ea; v.exp_wa = ew; v.exp_rw = er; v.exp_halt = ehl;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    id_t  addi, lw8, add8, lw0, add0, nop;
    vec_t tbl[11];
    logic [31:0] exp3;

    addi = '0; addi.aluctr = 5'b10000; addi.alusrc2 = 1'b1; addi.regwrite = 1'b1;
    addi.rs = 5'd1; addi.rt = 5'd5; addi.imm = 32'h0000_0010; addi.busa = 32'hA5A5_0001;
    addi.pc4 = 32'h0000_0104;
    lw8 = '0; lw8.memread = 2'b11; lw8.regwrite = 1'b1; lw8.memtoreg = 1'b1; lw8.alusrc2 = 1'b1;
    lw8.aluctr = 5'b00001; lw8.rs = 5'd2; lw8.rt = 5'd8; lw8.imm = 32'h0000_0020;
    lw8.pc4 = 32'h0000_0108;
    add8 = '0; add8.regdst = 1'b1; add8.regwrite = 1'b1; add8.aluctr = 5'b00010;
    add8.rs = 5'd8; add8.rt = 5'd3; add8.rd = 5'd9; add8.busb = 32'h1234_5678;
    add8.pc4 = 32'h0000_010C;
    lw0 = lw8; lw0.rt = 5'd0;
    add0 = add8; add0.rs = 5'd0;
    nop = '0;

    tbl[0]  = mkv(addi, 0, 0, 0, 5'b10000, 5'd5, 1, 0);
    tbl[1]  = mkv(lw8,  0, 0, 0, 5'b00001, 5'd8, 1, 0);
    tbl[2]  = mkv(add8, 0, 0, 1, 5'b00000, 5'd0, 0, 0);
    tbl[3]  = mkv(add8, 0, 0, 0, 5'b00010, 5'd9, 1, 0);
    tbl[4]  = mkv(lw0,  0, 0, 0, 5'b00001, 5'd0, 1, 0);
    tbl[5]  = mkv(add0, 0, 0, 0, 5'b00010, 5'd9, 1, 0);
    tbl[6]  = mkv(lw8,  0, 0, 0, 5'b00001, 5'd8, 1, 0);
    tbl[7]  = mkv(add8, 1, 1, 0, 5'b00000, 5'd0, 0, 0);
    tbl[8]  = mkv(addi, 0, 0, 0, 5'b10000, 5'd5, 1, 0);
    tbl[9]  = mkv(addi, 0, 1, 0, 5'b00000, 5'd0, 0, 1);
    tbl[10] = mkv(addi, 0, 0, 1, 5'b00000, 5'd0, 0, 1);

    // Reset for two cycles with random ID inputs
    rcycle(rand_id(), 1'b0, 1'b0, 1'b1);
    rcycle(rand_id(), 1'b1, 1'b1, 1'b1);
    chk("reset_ex_zero", {ex_act, ex_wa}, 200'd0);
    chk("reset_ctrl", ctrl, 1'b0);
    chk("reset_halt", halt, 1'b0);

    for (int i = 0; i < 11; i++) vcycle(i, tbl[i]);

    // Halt is sticky and ignores flush
    for (int i = 0; i < 20; i++) rcycle(addi, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("halt_sticky", halt, 1'b1);
    rcycle(addi, 1'b0, 1'b0, 1'b1);
    chk("halt_cleared", halt, 1'b0);
    rcycle(addi, 1'b0, 1'b0, 1'b0);
    chk("run_restored_aluctr", ex_aluctr, 5'b10000);

    // Three independent load-use pairs after a fresh reset
    rcycle(nop, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rcycle(lw8, 1'b0, 1'b0, 1'b0);
      rcycle(add8, 1'b0, 1'b0, 1'b0);
      rcycle(add8, 1'b0, 1'b0, 1'b0);
      rcycle(nop, 1'b0, 1'b0, 1'b0);
    end
`ifdef IDEX_STALL_STATS_EN
    exp3 = 32'd3;
`else
    exp3 = 32'd0;
`endif
    chk("stall_cnt_three_pairs", stall_cnt, exp3);

    for (int i = 0; i < 400; i++) begin
      rcycle(rand_id(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core.
- Registers the decoder's control bundle and operands into EX.
- Detects load-use hazards and drives the decoder's `ctrl` input to inject bubbles.
- Stops the pipeline permanently when the decoder flags an unsupported opcode (`keep`).

Parameters:
DW, 32, datapath width of busA/busB/imm/pc fields
RW, 5, register-address width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
id_regdst_i, id_branch_i, id_memtoreg_i, id_alusrc1_i, id_alusrc2_i, id_regwrite_i, id_jump_i  in  1 each  decoder control bits
id_memwrite_i, id_memread_i  in  2 each  00 none, 01 byte, 10 half, 11 word
id_aluctr_i  in  5  ALU operation code
id_keep_i  in  1  unsupported opcode in ID
id_rs_i, id_rt_i, id_rd_i, id_shamt_i  in  RW each  instruction fields
id_busa_i, id_busb_i, id_imm_i, id_pc4_i  in  DW each  operands, extended immediate, PC+4
flush_i  in  1  branch/jump taken at MEM; kill younger instructions
ex_*_o  out  (same widths as id_* inputs, excluding keep)  registered copies of all control and data fields
ex_wa_o  out  RW  write address = regdst ? rd : rt
ctrl_o  out  1  to decoder ctrl; forces ID controls to zero
pc_hold_o  out  1  PC write disable
ifid_hold_o  out  1  IF/ID register hold
halt_o  out  1  core halted on illegal instruction
stall_cnt_o  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge):
  - All ex_* outputs go to 0 and state goes to RUN.
  - halt_o=0; stall_cnt_o=0.
- States:
  - RUN: normal operation.
  - HALT: sticky; left only by reset.
- load_use (combinational) is 1 when all of the following hold:
  - ex_memread_o != 00 and ex_regwrite_o;
  - ex_wa_o != 0;
  - ex_wa_o == id_rs_i or ex_wa_o == id_rt_i.
- Per-cycle priority in RUN:
  - flush_i=1: ID/EX loads a bubble, meaning all control outputs 0, aluctr 0 and data fields 0. load_use and id_keep_i are ignored; holds 0.
  - else load_use=1: ID/EX loads a bubble; ctrl_o=1, pc_hold_o=1, ifid_hold_o=1.
  - else id_keep_i=1: ID/EX loads a bubble; next state is HALT.
  - else: ID/EX loads all id_* fields, and ex_wa_o is computed from id_regdst_i.
- Stall length: a load-use stall lasts exactly 1 cycle. The next cycle the load has moved to MEM, the ID/EX contents are a bubble, and the MEM→EX forwarding path resolves the dependency.
- HALT:
  - ctrl_o, pc_hold_o, ifid_hold_o and halt_o are all 1.
  - ID/EX loads a bubble every cycle.
  - flush_i has no effect.
- Output timing:
  - ctrl_o, pc_hold_o and ifid_hold_o are combinational from state and registered ex_* values, with no path from id_* control inputs other than id_rs_i and id_rt_i.
  - halt_o is registered, asserting the cycle after the edge that enters HALT.
- Latency: ID to EX is 1 cycle.

Optional Feature:
- Macro: IDEX_STALL_STATS_EN.
- Defined:
  - A 32-bit stall_cnt_o increments on each cycle with load_use=1 and flush_i=0 in RUN.
  - It saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is generated.

Decomposition:
- Package cpu_pkg holds:
  - the state enum (RUN, HALT);
  - MEM_NONE/MEM_BYTE/MEM_HALF/MEM_WORD codes;
  - the ALUCTR_W=5 constant;
  - a bubble-constant for the control bundle.
- Sub-module hazard_detect: purely combinational load_use compare, also reused by the forwarding unit.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random id_* → all ex_* 0, ctrl_o=0, halt_o=0.
- Pass-through: addi (aluctr 10000, alusrc2=1, regwrite=1, rt=5, regdst=0) → next cycle ex_aluctr_o=10000, ex_wa_o=5, no stall.
- Load-use: lw to $8 (memread 11, regwrite=1) followed by add with rs=$8 → exactly 1 cycle of ctrl_o=pc_hold_o=ifid_hold_o=1, then a bubble in EX, then add in EX. Same sequence with destination $0 → no stall.
- Flush priority: load-use condition, id_keep_i=1 and flush_i=1 in the same cycle → bubble, no hold, state stays RUN.
- Illegal op: id_keep_i=1 in RUN → halt_o=1 on the following cycle and holds stay high for 20 cycles. Then rst_n=0 → RUN restored.
- Stats (IDEX_STALL_STATS_EN defined): 3 independent load-use pairs → stall_cnt_o=3. With the macro undefined → stall_cnt_o=0.
